// File: rtl/boson_capture_packer_if.sv
// Output word stream of the Boson capture packer: show-ahead FIFO head with valid/ready handshake.
interface boson_capture_packer_if;
    logic [31:0] out_data;
    logic        out_sof;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, out_sof, out_valid, input out_ready);
    modport slave  (input out_data, out_sof, out_valid, output out_ready);
endinterface

// File: rtl/boson_capture_packer.sv
// Boson camera capture: VSYNC framing, 16->32 bit pixel packing with SOF tag, and a
// small show-ahead FIFO toward the frame writer. Overflow and short frames are sticky.
module boson_capture_packer #(
    parameter int DEPTH_LOG2  = 3,
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 512
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic                          enable,
    output logic                          busy,
    output logic [15:0]                   frame_count,
    output logic                          overflow,
    output logic                          short_frame,
    input  logic                          clr_err,
    input  logic [15:0]                   boson_data,
    input  logic                          boson_vsync,
    input  logic                          boson_valid,
    boson_capture_packer_if.master        stream
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int LW    = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [PW-1:0]         PIX_LAST  = PW'(LINE_PIXELS - 1);
    localparam logic [LW-1:0]         LINE_LAST = LW'(FRAME_LINES - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t                state;
    logic                  vsync_q;
    logic                  vs_rise;
    logic                  half;
    logic                  sof_pend;
    logic [15:0]           pix0;
    logic [PW-1:0]         pix_cnt;
    logic [LW-1:0]         line_cnt;
    logic                  restart;
    logic                  accept;
    logic                  frame_end;
    logic                  push;
    logic                  do_push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [32:0]           mem [DEPTH];
    logic [32:0]           head;

    assign vs_rise   = boson_vsync & ~vsync_q;
    // A VSYNC edge in ARMED (while enabled) or in CAPTURE both start a fresh frame.
    assign restart   = vs_rise && ((state == ARMED && enable) || state == CAPTURE);
    assign accept    = (state == CAPTURE) && boson_valid && !vs_rise;
    assign frame_end = accept && (pix_cnt == PIX_LAST) && (line_cnt == LINE_LAST);
    assign push      = accept && half;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            vsync_q     <= 1'b0;
            half        <= 1'b0;
            sof_pend    <= 1'b0;
            pix0        <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            frame_count <= '0;
            short_frame <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            vsync_q <= boson_vsync;

            if (clr_err)
                short_frame <= 1'b0;
            else if (state == CAPTURE && vs_rise)
                short_frame <= 1'b1;

            if (restart) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                half     <= 1'b0;
                sof_pend <= 1'b1;
            end else if (accept) begin
                if (!half) begin
                    pix0 <= boson_data;
                    half <= 1'b1;
                end else begin
                    half     <= 1'b0;
                    sof_pend <= 1'b0;
                end
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt <= '0;
                    if (line_cnt == LINE_LAST) line_cnt <= '0;
                    else                       line_cnt <= line_cnt + LW'(1);
                end else begin
                    pix_cnt <= pix_cnt + PW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_rise) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (frame_end) begin
                        frame_count <= frame_count + 16'd1;
                        if (enable) begin
                            state <= ARMED;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = !empty && stream.out_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign do_push = push && (!full || pop);

    // NOTE: storage is not reset; the output mux below hides stale entries when empty.
    always_ff @(posedge wb_clk) begin
        if (do_push) mem[wr_ptr] <= {sof_pend, boson_data, pix0};
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
            if (clr_err)
                overflow <= 1'b0;
            else if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    assign head             = mem[rd_ptr];
    assign stream.out_valid = !empty;
    assign stream.out_data  = empty ? '0 : head[31:0];
    assign stream.out_sof   = !empty && head[32];
endmodule
